// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: ID/EX-side inputs, stall back-pressure and registered outputs toward MEM.
interface ex_mem_stage_if;
    logic        flush_in;
    logic        BR_En_in;
    logic        Mem_to_BR_in;
    logic        Branch_in;
    logic        MemW_in;
    logic        MemR_in;
    logic        RegDst_in;
    logic        ALUSrc_in;
    logic [2:0]  AluOp_in;
    logic [31:0] PC_Plus4_in;
    logic [31:0] Dato1_in;
    logic [31:0] Dato2_in;
    logic [31:0] SignExt_in;
    logic [4:0]  Rt_in;
    logic [4:0]  Rd_in;
    logic [5:0]  Funct_in;
    logic        stall_out;
    logic        BR_En_out;
    logic        Mem_to_BR_out;
    logic        Branch_out;
    logic        MemW_out;
    logic        MemR_out;
    logic [31:0] AluResult_out;
    logic        Zero_out;
    logic [31:0] StoreData_out;
    logic [31:0] BranchTarget_out;
    logic [4:0]  WriteReg_out;

    modport master (
        output flush_in, BR_En_in, Mem_to_BR_in, Branch_in, MemW_in, MemR_in,
               RegDst_in, ALUSrc_in, AluOp_in, PC_Plus4_in, Dato1_in, Dato2_in,
               SignExt_in, Rt_in, Rd_in, Funct_in,
        input  stall_out, BR_En_out, Mem_to_BR_out, Branch_out, MemW_out, MemR_out,
               AluResult_out, Zero_out, StoreData_out, BranchTarget_out, WriteReg_out
    );

    modport slave (
        input  flush_in, BR_En_in, Mem_to_BR_in, Branch_in, MemW_in, MemR_in,
               RegDst_in, ALUSrc_in, AluOp_in, PC_Plus4_in, Dato1_in, Dato2_in,
               SignExt_in, Rt_in, Rd_in, Funct_in,
        output stall_out, BR_En_out, Mem_to_BR_out, Branch_out, MemW_out, MemR_out,
               AluResult_out, Zero_out, StoreData_out, BranchTarget_out, WriteReg_out
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage + EX/MEM register with an iterative shift-add multiplier that stalls the front end.
module ex_mem_stage (
    input logic          clk,
    input logic          reset,
    ex_mem_stage_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    typedef struct packed {
        logic        br_en;
        logic        mem_to_br;
        logic        branch;
        logic        memw;
        logic        memr;
        logic [31:0] alu_result;
        logic        zero;
        logic [31:0] store_data;
        logic [31:0] branch_target;
        logic [4:0]  write_reg;
    } ex_mem_t;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    ex_mem_t     ex_mem_q, ex_mem_d;

    logic [31:0] op_a, op_b, alu_result, result_sel;
    logic        mul_present, stall;

    // ALU: operand selection and combinational result for the current instruction
    always_comb begin
        op_a        = bus.Dato1_in;
        op_b        = bus.ALUSrc_in ? bus.SignExt_in : bus.Dato2_in;
        mul_present = (bus.AluOp_in == 3'b010) && (bus.Funct_in == FN_MUL);
        alu_result  = '0;
        case (bus.AluOp_in)
            3'b000: alu_result = op_a + op_b;
            3'b001: alu_result = op_a - op_b;
            3'b010: begin
                case (bus.Funct_in)
                    FN_ADD:  alu_result = op_a + op_b;
                    FN_SUB:  alu_result = op_a - op_b;
                    FN_AND:  alu_result = op_a & op_b;
                    FN_OR:   alu_result = op_a | op_b;
                    FN_NOR:  alu_result = ~(op_a | op_b);
                    FN_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
                    default: alu_result = '0;
                endcase
            end
            3'b011:  alu_result = op_a & op_b;
            3'b100:  alu_result = op_a | op_b;
            3'b101:  alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
            default: alu_result = op_a + op_b;
        endcase
    end

    // Multiplier FSM next-state: latch operands in IDLE, one shift-add step per BUSY cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mul_present) begin
                    stall    = 1'b1;
                    state_d  = S_BUSY;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_BUSY: begin
                stall    = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // held mul is still at the input here; it must not restart
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            stall = 1'b0;
        end
        if (bus.flush_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // EX/MEM next value: bubble under stall or flush, mul result in DONE, ALU result otherwise
    always_comb begin
        result_sel              = (state_q == S_DONE) ? acc_q : alu_result;
        ex_mem_d.br_en          = bus.BR_En_in;
        ex_mem_d.mem_to_br      = bus.Mem_to_BR_in;
        ex_mem_d.branch         = bus.Branch_in;
        ex_mem_d.memw           = bus.MemW_in;
        ex_mem_d.memr           = bus.MemR_in;
        ex_mem_d.alu_result     = result_sel;
        ex_mem_d.zero           = (result_sel == '0);
        ex_mem_d.store_data     = bus.Dato2_in;
        ex_mem_d.branch_target  = bus.PC_Plus4_in + (bus.SignExt_in << 2);
        ex_mem_d.write_reg      = bus.RegDst_in ? bus.Rd_in : bus.Rt_in;
        if (stall || bus.flush_in) begin
            ex_mem_d = '0;
        end
    end

    // State, multiplier datapath and EX/MEM registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ex_mem_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign bus.stall_out        = stall;
    assign bus.BR_En_out        = ex_mem_q.br_en;
    assign bus.Mem_to_BR_out    = ex_mem_q.mem_to_br;
    assign bus.Branch_out       = ex_mem_q.branch;
    assign bus.MemW_out         = ex_mem_q.memw;
    assign bus.MemR_out         = ex_mem_q.memr;
    assign bus.AluResult_out    = ex_mem_q.alu_result;
    assign bus.Zero_out         = ex_mem_q.zero;
    assign bus.StoreData_out    = ex_mem_q.store_data;
    assign bus.BranchTarget_out = ex_mem_q.branch_target;
    assign bus.WriteReg_out     = ex_mem_q.write_reg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases then randomized traffic against a cycle-count model.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: age = cycles since the mul was first seen (-1 = none in flight)
    int          age = -1;
    int          stall_cnt;
    logic        e_stall;
    logic [4:0]  e_ctrl;
    logic [31:0] e_res, e_store, e_tgt;
    logic        e_zero;
    logic [4:0]  e_wreg;
    logic [5:0]  fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h18, 6'h3F};

    function automatic logic [31:0] ref_alu(logic [2:0] op, logic [5:0] fn, logic [31:0] a, logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd1: return a - b;
            3'd2: begin
                case (fn)
                    6'h20:   return a + b;
                    6'h22:   return a - b;
                    6'h24:   return a & b;
                    6'h25:   return a | b;
                    6'h27:   return ~(a | b);
                    6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
                    default: return 32'd0;
                endcase
            end
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.flush_in = 0; bus.BR_En_in = 0; bus.Mem_to_BR_in = 0; bus.Branch_in = 0;
        bus.MemW_in = 0; bus.MemR_in = 0; bus.RegDst_in = 0; bus.ALUSrc_in = 0;
        bus.AluOp_in = 0; bus.PC_Plus4_in = 0; bus.Dato1_in = 0; bus.Dato2_in = 0;
        bus.SignExt_in = 0; bus.Rt_in = 0; bus.Rd_in = 0; bus.Funct_in = 0;
    endtask

    task automatic set_mul(input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        bus.AluOp_in = 3'b010; bus.Funct_in = 6'h18; bus.Dato1_in = a; bus.Dato2_in = b;
        bus.RegDst_in = 1; bus.Rd_in = 5'd17; bus.Rt_in = 5'd3; bus.BR_En_in = 1;
        bus.PC_Plus4_in = 32'h40; bus.SignExt_in = 32'h3;
    endtask

    task automatic rand_inputs();
        bus.BR_En_in = 1'($urandom); bus.Mem_to_BR_in = 1'($urandom); bus.Branch_in = 1'($urandom);
        bus.MemW_in = 1'($urandom); bus.MemR_in = 1'($urandom); bus.RegDst_in = 1'($urandom);
        bus.ALUSrc_in = 1'($urandom); bus.AluOp_in = 3'($urandom_range(0, 7));
        bus.Funct_in = fns[$urandom_range(0, 7)];
        if ($urandom_range(0, 7) == 0) begin
            bus.AluOp_in = 3'b010; bus.Funct_in = 6'h18;
        end
        bus.PC_Plus4_in = $urandom; bus.Dato1_in = $urandom; bus.SignExt_in = $urandom;
        bus.Dato2_in = ($urandom_range(0, 3) == 0) ? bus.Dato1_in : $urandom;
        bus.Rt_in = 5'($urandom); bus.Rd_in = 5'($urandom);
    endtask

    // one clock: check stall, predict the registered outputs, clock, check outputs
    task automatic cycle();
        logic [31:0] a, b;
        logic        mul_in;
        logic [63:0] p;
        #1;
        a      = bus.Dato1_in;
        b      = bus.ALUSrc_in ? bus.SignExt_in : bus.Dato2_in;
        mul_in = (bus.AluOp_in == 3'b010) && (bus.Funct_in == 6'h18);
        if (reset) begin
            e_stall = 0;
        end else begin
            if (age < 0 && mul_in) age = 0;
            e_stall = (age >= 0 && age <= 32);
        end
        check("stall", {31'd0, bus.stall_out}, {31'd0, e_stall});
        if (e_stall) stall_cnt++;
        if (reset || bus.flush_in || e_stall) begin
            e_ctrl = 0; e_res = 0; e_zero = 0; e_store = 0; e_tgt = 0; e_wreg = 0;
        end else begin
            e_ctrl = {bus.BR_En_in, bus.Mem_to_BR_in, bus.Branch_in, bus.MemW_in, bus.MemR_in};
            p      = 64'(a) * 64'(b);
            e_res  = (age == 33) ? p[31:0] : ref_alu(bus.AluOp_in, bus.Funct_in, a, b);
            e_zero = (e_res == 0);
            e_store = bus.Dato2_in;
            e_tgt  = bus.PC_Plus4_in + bus.SignExt_in * 4;
            e_wreg = bus.RegDst_in ? bus.Rd_in : bus.Rt_in;
        end
        if (reset || bus.flush_in || age == 33) age = -1;
        else if (age >= 0) age++;
        @(posedge clk);
        #1;
        check("ctrl", {27'd0, bus.BR_En_out, bus.Mem_to_BR_out, bus.Branch_out, bus.MemW_out, bus.MemR_out},
              {27'd0, e_ctrl});
        check("alu_result", bus.AluResult_out, e_res);
        check("zero", {31'd0, bus.Zero_out}, {31'd0, e_zero});
        check("store_data", bus.StoreData_out, e_store);
        check("branch_target", bus.BranchTarget_out, e_tgt);
        check("write_reg", {27'd0, bus.WriteReg_out}, {27'd0, e_wreg});
    endtask

    initial begin
        // reset with every input nonzero (including flush) and a mul present
        reset = 1;
        bus.flush_in = 1; bus.BR_En_in = 1; bus.Mem_to_BR_in = 1; bus.Branch_in = 1;
        bus.MemW_in = 1; bus.MemR_in = 1; bus.RegDst_in = 1; bus.ALUSrc_in = 1;
        bus.AluOp_in = 3'b010; bus.Funct_in = 6'h18; bus.PC_Plus4_in = 32'h11;
        bus.Dato1_in = 32'h22; bus.Dato2_in = 32'h33; bus.SignExt_in = 32'h44;
        bus.Rt_in = 5'd1; bus.Rd_in = 5'd2;
        cycle();
        cycle();
        check("reset_stall", {31'd0, bus.stall_out}, 32'd0);
        check("reset_alu", bus.AluResult_out, 32'd0);
        reset = 0;
        clear_inputs();

        // R-type add with wrap
        bus.AluOp_in = 3'b010; bus.Funct_in = 6'h20; bus.Dato1_in = 32'd5; bus.Dato2_in = 32'hFFFF_FFFF;
        bus.RegDst_in = 1; bus.Rd_in = 5'd9; bus.BR_En_in = 1;
        cycle();
        check("add_res", bus.AluResult_out, 32'd4);
        check("add_wreg", {27'd0, bus.WriteReg_out}, 32'd9);

        // beq taken
        clear_inputs();
        bus.AluOp_in = 3'b001; bus.Dato1_in = 32'h1234; bus.Dato2_in = 32'h1234;
        bus.PC_Plus4_in = 32'h100; bus.SignExt_in = 32'hFFFF_FFFE; bus.Branch_in = 1;
        cycle();
        check("beq_zero", {31'd0, bus.Zero_out}, 32'd1);
        check("beq_target", bus.BranchTarget_out, 32'hF8);

        // slt signed
        clear_inputs();
        bus.AluOp_in = 3'b101; bus.Dato1_in = 32'hFFFF_FFFF; bus.Dato2_in = 32'd1;
        cycle();
        check("slt_res", bus.AluResult_out, 32'd1);

        // lw address
        clear_inputs();
        bus.AluOp_in = 3'b000; bus.ALUSrc_in = 1; bus.Dato1_in = 32'h1000; bus.SignExt_in = 32'h10;
        bus.Rt_in = 5'd4; bus.Rd_in = 5'd12; bus.MemR_in = 1;
        cycle();
        check("lw_addr", bus.AluResult_out, 32'h1010);
        check("lw_wreg", {27'd0, bus.WriteReg_out}, 32'd4);

        // mul 7 x 6 held under stall
        set_mul(32'd7, 32'd6);
        stall_cnt = 0;
        repeat (34) cycle();
        check("mul_stall_len", stall_cnt, 32'd33);
        check("mul_res", bus.AluResult_out, 32'd42);

        // back-to-back mul
        set_mul(32'hFFFF_FFFF, 32'd2);
        stall_cnt = 0;
        repeat (34) cycle();
        check("mul2_stall_len", stall_cnt, 32'd33);
        check("mul2_res", bus.AluResult_out, 32'hFFFF_FFFE);

        // flush at BUSY counter 10
        set_mul(32'd9, 32'd9);
        repeat (11) cycle();
        bus.flush_in = 1;
        cycle();
        check("flush_bubble", bus.AluResult_out, 32'd0);
        clear_inputs();
        bus.AluOp_in = 3'b000; bus.Dato1_in = 32'd3; bus.Dato2_in = 32'd4;
        cycle();
        check("flush_nomul", bus.AluResult_out, 32'd7);
        repeat (3) cycle();

        // reset at BUSY counter 20
        set_mul(32'd11, 32'd13);
        repeat (21) cycle();
        reset = 1;
        cycle();
        reset = 0;
        clear_inputs();
        repeat (4) cycle();

        // randomized traffic; inputs held while the model expects a stall
        for (int i = 0; i < 400; i++) begin
            if (!e_stall) rand_inputs();
            bus.flush_in = ($urandom_range(0, 63) == 0);
            reset        = ($urandom_range(0, 127) == 0);
            cycle();
        end
        reset = 0;
        bus.flush_in = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
